gray_sweep_ctrl: RTL and testbench

Sequencer for the binary-to-Gray conversion datapath. On command, it sweeps a programmable run of binary codes through a binary-to-Gray stage, one code per cycle. Each code is presented as a {binary, Gray} pair on a valid/ready output stream. The block sits between a control/register interface and a downstream consumer, such as a display or a Gray-coded pointer sink, and optionally self-checks single-bit adjacency.

---
 rtl/gray_sweep_pkg.sv | 20 ++
 rtl/gray_conv.sv | 20 ++
 rtl/gray_sweep_ctrl.sv | 143 ++++++++++++++
 tb/tb_gray_sweep_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/gray_sweep_pkg.sv
// Shared types, direction encoding and the reference binary-to-Gray function
// used by the gray_sweep_ctrl sequencer.
package gray_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  localparam int GS_WIDTH = 4;

  function automatic logic [GS_WIDTH-1:0] bin2gray(input logic [GS_WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_conv.sv
// Purely combinational WIDTH-bit binary-to-Gray converter.
module gray_conv
  import gray_sweep_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] bin_i,
  output logic [WIDTH-1:0] gray_o
);

  // The package function is fixed-width; other widths use the same identity inline.
  generate
    if (WIDTH == GS_WIDTH) begin : g_pkg
      assign gray_o = bin2gray(bin_i);
    end else begin : g_inline
      assign gray_o = bin_i ^ (bin_i >> 1);
    end
  endgenerate

endmodule

// File: rtl/gray_sweep_ctrl.sv
// Sweeps a programmable run of binary codes through a Gray converter onto a
// valid/ready stream. Define GRAY_ADJ_CHECK_EN to add the sticky adjacency checker.
module gray_sweep_ctrl
  import gray_sweep_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int LEN_W = WIDTH + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             dir,
  input  logic [WIDTH-1:0] start_val,
  input  logic [LEN_W-1:0] run_len,
  output logic [WIDTH-1:0] out_bin,
  output logic [WIDTH-1:0] out_gray,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [LEN_W-1:0] FULL_RUN = LEN_W'(1) << WIDTH;

  state_e           state_q;
  logic [WIDTH-1:0] outBin_q;
  logic [WIDTH-1:0] outGray_q;
  logic             outValid_q;
  logic             busy_q;
  logic             done_q;
  logic             dir_q;
  logic [LEN_W-1:0] remaining_q;

  logic [WIDTH-1:0] outBin_d;
  logic [WIDTH-1:0] outGray_d;
  logic             xfer;

  assign xfer = outValid_q && out_ready;

  // In IDLE the converter sees the start code so the first pair is ready one cycle after start.
  always_comb begin
    outBin_d = outBin_q;
    if (state_q == IDLE) begin
      outBin_d = start_val;
    end else if (dir_q == DIR_DN) begin
      outBin_d = outBin_q - WIDTH'(1);
    end else begin
      outBin_d = outBin_q + WIDTH'(1);
    end
  end

  gray_conv #(.WIDTH(WIDTH)) u_conv (
    .bin_i  (outBin_d),
    .gray_o (outGray_d)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      outBin_q    <= '0;
      outGray_q   <= '0;
      outValid_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dir_q       <= DIR_UP;
      remaining_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q     <= RUN;
            outBin_q    <= outBin_d;
            outGray_q   <= outGray_d;
            remaining_q <= (run_len == '0) ? FULL_RUN : run_len;
            dir_q       <= dir;
            outValid_q  <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        RUN: begin
          if (abort || (xfer && remaining_q <= LEN_W'(1))) begin
            state_q    <= DONE;
            outValid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
          end else if (xfer) begin
            outBin_q    <= outBin_d;
            outGray_q   <= outGray_d;
            remaining_q <= remaining_q - LEN_W'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q    <= IDLE;
          outValid_q <= 1'b0;
          busy_q     <= 1'b0;
          done_q     <= 1'b0;
        end
      endcase
    end
  end

  assign out_bin   = outBin_q;
  assign out_gray  = outGray_q;
  assign out_valid = outValid_q;
  assign busy      = busy_q;
  assign done      = done_q;

`ifdef GRAY_ADJ_CHECK_EN
  logic [WIDTH-1:0] prevGray_q;
  logic             havePrev_q;
  logic             err_q;

  // Compares each accepted Gray code with the previously accepted one; any non-unit step latches err.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prevGray_q <= '0;
      havePrev_q <= 1'b0;
      err_q      <= 1'b0;
    end else if (state_q == IDLE && start) begin
      havePrev_q <= 1'b0;
      err_q      <= 1'b0;
    end else if (state_q == RUN && !abort && xfer) begin
      if (havePrev_q && ($countones(outGray_q ^ prevGray_q) != 1)) begin
        err_q <= 1'b1;
      end
      prevGray_q <= outGray_q;
      havePrev_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_gray_sweep_ctrl.sv
// Directed, table-driven bench for gray_sweep_ctrl; the adjacency-error
// sequence runs only when GRAY_ADJ_CHECK_EN is defined.
module tb_gray_sweep_ctrl;

  typedef struct {
    logic       rstN;
    logic       start;
    logic       abort;
    logic       dir;
    logic [3:0] startVal;
    logic [4:0] runLen;
    logic       ready;
    logic [3:0] bin;
    logic [3:0] gray;
    logic       valid;
    logic       busy;
    logic       done;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic       dir;
  logic [3:0] start_val;
  logic [4:0] run_len;
  logic [3:0] out_bin;
  logic [3:0] out_gray;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       done;
  logic       err;

  int   checkCount = 0;
  int   passCount  = 0;
  int   xferCount  = 0;
  vec_t vecs[$];
  logic [3:0] grayTab [16];

  gray_sweep_ctrl #(.WIDTH(4), .LEN_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .dir       (dir),
    .start_val (start_val),
    .run_len   (run_len),
    .out_bin   (out_bin),
    .out_gray  (out_gray),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent count of handshakes seen by the consumer.
  always @(posedge clk) begin
    if (rst_n && out_valid && out_ready) xferCount++;
  end

  function automatic void addVec(input logic rstN, input logic st, input logic ab,
                                 input logic d, input logic [3:0] sv, input logic [4:0] rl,
                                 input logic rdy, input logic [3:0] b, input logic [3:0] g,
                                 input logic v, input logic bz, input logic dn);
    vec_t t;
    t.rstN = rstN; t.start = st; t.abort = ab; t.dir = d; t.startVal = sv; t.runLen = rl;
    t.ready = rdy; t.bin = b; t.gray = g; t.valid = v; t.busy = bz; t.done = dn;
    vecs.push_back(t);
  endfunction

  task automatic applyStimulus(input vec_t v);
    rst_n     = v.rstN;
    start     = v.start;
    abort     = v.abort;
    dir       = v.dir;
    start_val = v.startVal;
    run_len   = v.runLen;
    out_ready = v.ready;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Outputs are packed as {bin, gray, valid, busy, done, err}; err is always expected 0 here.
  task automatic runGroup(input string tag, input int expXfers);
    int base;
    base = xferCount;
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("%s[%0d]", tag, i),
                  {20'd0, out_bin, out_gray, out_valid, busy, done, err},
                  {20'd0, vecs[i].bin, vecs[i].gray, vecs[i].valid, vecs[i].busy,
                   vecs[i].done, 1'b0});
    end
    checkOutput({tag, "_xfers"}, xferCount - base, expXfers);
    vecs.delete();
  endtask

  initial begin
    vec_t v;
    grayTab = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; dir = 1'b0;
    start_val = 4'h0; run_len = 5'd0; out_ready = 1'b0;
    @(posedge clk);
    #1;

    // Reset state, then a full 16-code upward sweep (run_len=0).
    addVec(0, 0, 0, 0, 4'h0, 5'd0, 1, 4'h0, 4'h0, 0, 0, 0);
    addVec(1, 1, 0, 0, 4'h0, 5'd0, 1, 4'h0, 4'h0, 1, 1, 0);
    for (int k = 1; k < 16; k++) begin
      addVec(1, 0, 0, 0, 4'h0, 5'd0, 1, 4'(k), grayTab[k], 1, 1, 0);
    end
    addVec(1, 0, 0, 0, 4'h0, 5'd0, 1, 4'hF, 4'h8, 0, 0, 1);
    addVec(1, 0, 0, 0, 4'h0, 5'd0, 1, 4'hF, 4'h8, 0, 0, 0);
    runGroup("full", 16);

    // Wrap F->0; abort together with start in IDLE is ignored.
    addVec(1, 1, 1, 0, 4'hE, 5'd4, 1, 4'hE, 4'h9, 1, 1, 0);
    addVec(1, 0, 0, 0, 4'h0, 5'd0, 1, 4'hF, 4'h8, 1, 1, 0);
    addVec(1, 0, 0, 0, 4'h0, 5'd0, 1, 4'h0, 4'h0, 1, 1, 0);
    addVec(1, 0, 0, 0, 4'h0, 5'd0, 1, 4'h1, 4'h1, 1, 1, 0);
    addVec(1, 0, 0, 0, 4'h0, 5'd0, 1, 4'h1, 4'h1, 0, 0, 1);
    addVec(1, 0, 0, 0, 4'h0, 5'd0, 1, 4'h1, 4'h1, 0, 0, 0);
    runGroup("wrap", 4);

    // Decrement with back-pressure; dir/start_val changed after start must not matter.
    addVec(1, 1, 0, 1, 4'h3, 5'd3, 0, 4'h3, 4'h2, 1, 1, 0);
    addVec(1, 0, 0, 0, 4'h8, 5'd9, 1, 4'h2, 4'h3, 1, 1, 0);
    addVec(1, 0, 0, 0, 4'h8, 5'd9, 0, 4'h2, 4'h3, 1, 1, 0);
    addVec(1, 0, 0, 0, 4'h8, 5'd9, 0, 4'h2, 4'h3, 1, 1, 0);
    addVec(1, 0, 0, 0, 4'h8, 5'd9, 1, 4'h1, 4'h1, 1, 1, 0);
    addVec(1, 0, 0, 0, 4'h8, 5'd9, 0, 4'h1, 4'h1, 1, 1, 0);
    addVec(1, 0, 0, 0, 4'h8, 5'd9, 1, 4'h1, 4'h1, 0, 0, 1);
    addVec(1, 0, 0, 0, 4'h8, 5'd9, 0, 4'h1, 4'h1, 0, 0, 0);
    runGroup("down", 3);

    // Abort after two transfers; starts in RUN and DONE are dropped, abort in IDLE ignored.
    addVec(1, 1, 0, 0, 4'h0, 5'd10, 1, 4'h0, 4'h0, 1, 1, 0);
    addVec(1, 0, 0, 0, 4'h0, 5'd10, 1, 4'h1, 4'h1, 1, 1, 0);
    addVec(1, 0, 0, 0, 4'h0, 5'd10, 1, 4'h2, 4'h3, 1, 1, 0);
    addVec(1, 1, 0, 0, 4'h7, 5'd10, 0, 4'h2, 4'h3, 1, 1, 0);
    addVec(1, 0, 1, 0, 4'h7, 5'd10, 0, 4'h2, 4'h3, 0, 0, 1);
    addVec(1, 1, 0, 0, 4'h7, 5'd10, 1, 4'h2, 4'h3, 0, 0, 0);
    addVec(1, 0, 1, 0, 4'h7, 5'd10, 1, 4'h2, 4'h3, 0, 0, 0);
    runGroup("abort", 2);

    // Reset mid-sweep gives no done pulse; a later one-code sweep runs normally.
    addVec(1, 1, 0, 0, 4'h5, 5'd8, 1, 4'h5, 4'h7, 1, 1, 0);
    addVec(1, 0, 0, 0, 4'h5, 5'd8, 1, 4'h6, 4'h5, 1, 1, 0);
    addVec(0, 0, 0, 0, 4'h5, 5'd8, 1, 4'h0, 4'h0, 0, 0, 0);
    addVec(1, 0, 0, 0, 4'h5, 5'd8, 1, 4'h0, 4'h0, 0, 0, 0);
    addVec(1, 1, 0, 0, 4'h9, 5'd1, 1, 4'h9, 4'hD, 1, 1, 0);
    addVec(1, 0, 0, 0, 4'h9, 5'd1, 1, 4'h9, 4'hD, 0, 0, 1);
    addVec(1, 0, 0, 0, 4'h9, 5'd1, 1, 4'h9, 4'hD, 0, 0, 0);
    runGroup("rst", 2);

`ifdef GRAY_ADJ_CHECK_EN
    // Deposit a skipped code mid-sweep; err must latch and hold until the next start.
    v = '{rstN: 1, start: 1, abort: 0, dir: 0, startVal: 4'h0, runLen: 5'd8, ready: 1,
          bin: 4'h0, gray: 4'h0, valid: 0, busy: 0, done: 0};
    applyStimulus(v);
    v.start = 1'b0;
    applyStimulus(v);
    checkOutput("adj_bin1", out_bin, 4'h1);
    v.ready = 1'b0;
    applyStimulus(v);
    dut.outBin_q = 4'h2;
    v.ready = 1'b1;
    applyStimulus(v);
    checkOutput("adj_err_before", err, 1'b0);
    applyStimulus(v);
    checkOutput("adj_err_set", err, 1'b1);
    v.abort = 1'b1;
    applyStimulus(v);
    checkOutput("adj_done", done, 1'b1);
    v.abort = 1'b0;
    applyStimulus(v);
    applyStimulus(v);
    checkOutput("adj_err_sticky", err, 1'b1);
    v.start = 1'b1;
    applyStimulus(v);
    checkOutput("adj_err_clr", err, 1'b0);
    v.start = 1'b0;
    v.abort = 1'b1;
    applyStimulus(v);
    v.abort = 1'b0;
    applyStimulus(v);
`else
    v = '{rstN: 1, start: 1, abort: 0, dir: 1, startVal: 4'h4, runLen: 5'd2, ready: 1,
          bin: 4'h0, gray: 4'h0, valid: 0, busy: 0, done: 0};
    applyStimulus(v);
    v.start = 1'b0;
    applyStimulus(v);
    applyStimulus(v);
    checkOutput("noadj_done", done, 1'b1);
    checkOutput("noadj_err", err, 1'b0);
    applyStimulus(v);
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
